// File: rtl/ldpc_serial_port.sv
// Multi-lane serial pin bridge between the user-area pins and the LDPC core:
// assembles load frames into a word and serialises unload words onto the pins.
module ldpc_serial_port #(
  parameter int WIDTH = 208,
  parameter int LANES = 1,
  parameter int SEL_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             P_inputnoutput,
  input  logic             P_valid_i,
  input  logic [LANES-1:0] P_input,
  input  logic [SEL_W-1:0] P_in_out_sel,
  output logic [LANES-1:0] PO_output,
  output logic             PO_valid_o,
  output logic [WIDTH-1:0] ld_data_o,
  output logic [SEL_W-1:0] ld_sel_o,
  output logic             ld_valid_o,
  input  logic             ld_ready_i,
  input  logic [WIDTH-1:0] ul_data_i,
  input  logic             ul_valid_i,
  output logic             ul_ready_o,
  output logic             busy_o,
  output logic             err_o,
  input  logic             err_clr_i
);

  localparam int BEATS = (WIDTH + LANES - 1) / LANES;
  localparam int BUF_W = BEATS * LANES;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_HOLD_IN,
    S_WAIT_UL,
    S_SHIFT_OUT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BUF_W-1:0]   r_buf;
  logic [BUF_W-1:0]   w_buf_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [LANES-1:0]   r_po;
  logic [LANES-1:0]   w_po_nxt;
  logic               r_po_vld;
  logic               w_po_vld_nxt;
  logic               r_err;
  logic               w_err_set;
  logic               w_frame_start;
  logic [BUF_W-1:0]   w_load_shift;
  logic [BUF_W-1:0]   w_ul_ext;

  // New beats enter at the top and move down one beat per capture, so beat 0
  // ends at bit 0 once the frame is complete; pad bits land above WIDTH.
  assign w_load_shift = (r_buf >> LANES) | (BUF_W'(P_input) << (BUF_W - LANES));
  assign w_ul_ext     = BUF_W'(ul_data_i);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, otherwise any path
  // that skips an assignment would infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_buf_nxt     = r_buf;
    w_cnt_nxt     = r_cnt;
    w_po_nxt      = '0;
    w_po_vld_nxt  = 1'b0;
    w_err_set     = 1'b0;
    w_frame_start = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (P_valid_i) begin
          w_frame_start = 1'b1;
          if (P_inputnoutput) begin
            w_buf_nxt   = w_load_shift;
            w_cnt_nxt   = (BEATS == 1) ? '0 : CNT_ONE;
            w_state_nxt = (BEATS == 1) ? S_HOLD_IN : S_SHIFT_IN;
          end else begin
            w_state_nxt = S_WAIT_UL;
          end
        end
      end

      S_SHIFT_IN: begin
        if (P_valid_i) begin
          w_buf_nxt = w_load_shift;
          if (r_cnt == LAST_IN) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_HOLD_IN;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end

      S_HOLD_IN: begin
        w_err_set = P_valid_i;
        if (ld_ready_i) w_state_nxt = S_IDLE;
      end

      S_WAIT_UL: begin
        w_err_set = P_valid_i;
        if (ul_valid_i) begin
          w_po_nxt     = w_ul_ext[LANES-1:0];
          w_po_vld_nxt = 1'b1;
          w_buf_nxt    = w_ul_ext >> LANES;
          w_cnt_nxt    = CNT_ONE;
          w_state_nxt  = S_SHIFT_OUT;
        end
      end

      S_SHIFT_OUT: begin
        w_err_set = P_valid_i;
        // r_cnt is the number of beats already on the pins.
        if (r_cnt == LAST_OUT) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_po_nxt     = r_buf[LANES-1:0];
          w_po_vld_nxt = 1'b1;
          w_buf_nxt    = r_buf >> LANES;
          w_cnt_nxt    = r_cnt + CNT_ONE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the frame buffer is a plain register vector, so it takes the reset
  // like any other flop; a reset mid-frame must leave no partial word behind.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_buf    <= '0;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_po     <= '0;
      r_po_vld <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_buf    <= w_buf_nxt;
      r_cnt    <= w_cnt_nxt;
      r_po     <= w_po_nxt;
      r_po_vld <= w_po_vld_nxt;
      if (w_frame_start) r_sel <= P_in_out_sel;
      if (w_err_set)      r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

  // The buffer is shared by both directions; ld_data_o is only meaningful
  // while ld_valid_o is high, and nothing writes the buffer in HOLD_IN.
  assign ld_data_o  = r_buf[WIDTH-1:0];
  assign ld_sel_o   = r_sel;
  assign ld_valid_o = (r_state == S_HOLD_IN);
  assign ul_ready_o = (r_state == S_WAIT_UL);
  assign busy_o     = (r_state != S_IDLE);
  assign PO_output  = r_po;
  assign PO_valid_o = r_po_vld;
  assign err_o      = r_err;

endmodule

// File: tb/tb_ldpc_serial_port.sv
// Self-checking bench: three bridges (1, 4 and 5 lanes) driven with directed
// and random frames, compared against word-level bit-order rules.
module tb_ldpc_serial_port;

  localparam int W  = 208;
  localparam int SW = 16;
  localparam int NI = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          p_dir    [NI];
  logic          p_valid  [NI];
  logic [4:0]    p_in     [NI];
  logic [SW-1:0] p_sel    [NI];
  logic          ld_ready [NI];
  logic [W-1:0]  ul_data  [NI];
  logic          ul_valid [NI];
  logic          err_clr  [NI];

  logic [4:0]    po_out   [NI];
  logic          po_valid [NI];
  logic [W-1:0]  ld_data  [NI];
  logic [SW-1:0] ld_sel   [NI];
  logic          ld_valid [NI];
  logic          ul_ready [NI];
  logic          busy     [NI];
  logic          err      [NI];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 4 : 5;
    logic [L-1:0] w_po;
    ldpc_serial_port #(.WIDTH(W), .LANES(L), .SEL_W(SW)) u_dut (
      .wb_clk_i       (clk),
      .wb_rst_ni      (rst_n),
      .P_inputnoutput (p_dir[g]),
      .P_valid_i      (p_valid[g]),
      .P_input        (p_in[g][L-1:0]),
      .P_in_out_sel   (p_sel[g]),
      .PO_output      (w_po),
      .PO_valid_o     (po_valid[g]),
      .ld_data_o      (ld_data[g]),
      .ld_sel_o       (ld_sel[g]),
      .ld_valid_o     (ld_valid[g]),
      .ld_ready_i     (ld_ready[g]),
      .ul_data_i      (ul_data[g]),
      .ul_valid_i     (ul_valid[g]),
      .ul_ready_o     (ul_ready[g]),
      .busy_o         (busy[g]),
      .err_o          (err[g]),
      .err_clr_i      (err_clr[g])
    );
    assign po_out[g] = 5'(w_po);
  end

  function automatic int lanes_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int beats_of(input int k);
    return (W + lanes_of(k) - 1) / lanes_of(k);
  endfunction

  // Pin value for beat b: lane l carries word bit b*LANES+l; positions past
  // the word (and unused tb lanes) are random when rand_pad, else 0.
  function automatic logic [4:0] beat_of(input logic [W-1:0] w, input int k,
                                         input int b, input bit rand_pad);
    logic [4:0] r;
    r = rand_pad ? 5'($urandom) : 5'd0;
    for (int l = 0; l < lanes_of(k); l++)
      if (b * lanes_of(k) + l < W) r[l] = w[b * lanes_of(k) + l];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  task automatic check(input string tag, input int k,
                       input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[u%0d]: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input int k, input string tag);
    check({tag, "_ld_data"}, k, ld_data[k], '0);
    check({tag, "_ld_sel"}, k, W'(ld_sel[k]), '0);
    check({tag, "_ld_valid"}, k, W'(ld_valid[k]), '0);
    check({tag, "_ul_ready"}, k, W'(ul_ready[k]), '0);
    check({tag, "_busy"}, k, W'(busy[k]), '0);
    check({tag, "_err"}, k, W'(err[k]), '0);
    check({tag, "_po_valid"}, k, W'(po_valid[k]), '0);
    check({tag, "_po_out"}, k, W'(po_out[k]), '0);
  endtask

  // Drives nb load beats starting at frame start; returns on the negedge
  // after the last beat was sampled, with p_valid low.
  task automatic send_beats(input int k, input logic [W-1:0] word,
                            input logic [SW-1:0] sel, input int nb, input bit gaps);
    for (int b = 0; b < nb; b++) begin
      if (gaps && b > 0 && $urandom_range(0, 3) == 0) begin
        p_valid[k] = 1'b0;
        p_in[k]    = 5'($urandom);
        p_dir[k]   = 1'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      p_valid[k] = 1'b1;
      p_in[k]    = beat_of(word, k, b, 1'b1);
      p_dir[k]   = (b == 0) ? 1'b1 : 1'($urandom);
      p_sel[k]   = (b == 0) ? sel : SW'($urandom);
      @(negedge clk);
    end
    p_valid[k] = 1'b0;
  endtask

  task automatic load_frame(input int k, input logic [W-1:0] word,
                            input logic [SW-1:0] sel, input bit gaps,
                            input int hold, input bit hold_err);
    send_beats(k, word, sel, beats_of(k), gaps);
    check("ld_valid_rise", k, W'(ld_valid[k]), W'(1'b1));
    check("ld_data", k, ld_data[k], word);
    check("ld_sel", k, W'(ld_sel[k]), W'(sel));
    check("busy_load", k, W'(busy[k]), W'(1'b1));
    for (int h = 0; h < hold; h++) begin
      if (hold_err && h == 0) begin
        p_valid[k] = 1'b1;
        p_dir[k]   = 1'b1;
        p_in[k]    = 5'($urandom);
      end
      @(negedge clk);
      p_valid[k] = 1'b0;
      check("ld_valid_hold", k, W'(ld_valid[k]), W'(1'b1));
      check("ld_data_hold", k, ld_data[k], word);
      check("ld_sel_hold", k, W'(ld_sel[k]), W'(sel));
    end
    if (hold_err) check("err_hold_in", k, W'(err[k]), W'(1'b1));
    ld_ready[k] = 1'b1;
    @(negedge clk);
    ld_ready[k] = 1'b0;
    check("ld_valid_drop", k, W'(ld_valid[k]), '0);
    check("busy_load_end", k, W'(busy[k]), '0);
  endtask

  task automatic unload_frame(input int k, input logic [W-1:0] word,
                              input logic [SW-1:0] sel, input int wait_n,
                              input int err_beat, input bit clr_test);
    p_valid[k] = 1'b1;
    p_dir[k]   = 1'b0;
    p_sel[k]   = sel;
    p_in[k]    = 5'($urandom);
    @(negedge clk);
    p_valid[k] = 1'b0;
    p_sel[k]   = SW'($urandom);
    check("ul_ready_rise", k, W'(ul_ready[k]), W'(1'b1));
    check("busy_unload", k, W'(busy[k]), W'(1'b1));
    check("ul_sel", k, W'(ld_sel[k]), W'(sel));
    check("po_valid_wait", k, W'(po_valid[k]), '0);
    if (clr_test) begin
      err_clr[k] = 1'b1;
      p_valid[k] = 1'b1;
      @(negedge clk);
      p_valid[k] = 1'b0;
      check("err_set_wins", k, W'(err[k]), W'(1'b1));
      @(negedge clk);
      err_clr[k] = 1'b0;
      check("err_cleared", k, W'(err[k]), '0);
      check("ul_ready_after_err", k, W'(ul_ready[k]), W'(1'b1));
    end
    repeat (wait_n) begin
      @(negedge clk);
      check("ul_ready_hold", k, W'(ul_ready[k]), W'(1'b1));
    end
    ul_valid[k] = 1'b1;
    ul_data[k]  = word;
    @(negedge clk);
    ul_valid[k] = 1'b0;
    ul_data[k]  = rand_word();
    check("ul_ready_fall", k, W'(ul_ready[k]), '0);
    for (int b = 0; b < beats_of(k); b++) begin
      check("po_valid", k, W'(po_valid[k]), W'(1'b1));
      check("po_beat", k, W'(po_out[k]), W'(beat_of(word, k, b, 1'b0)));
      if (b == err_beat) begin
        p_valid[k] = 1'b1;
        p_dir[k]   = 1'($urandom);
      end
      @(negedge clk);
      p_valid[k] = 1'b0;
    end
    check("po_valid_end", k, W'(po_valid[k]), '0);
    check("po_out_end", k, W'(po_out[k]), '0);
    check("busy_unload_end", k, W'(busy[k]), '0);
    if (err_beat >= 0) check("err_shift_out", k, W'(err[k]), W'(1'b1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] w;
    logic [223:0] rep;
    for (int k = 0; k < NI; k++) begin
      p_dir[k] = 1'b0; p_valid[k] = 1'b0; p_in[k] = '0; p_sel[k] = '0;
      ld_ready[k] = 1'b0; ul_data[k] = '0; ul_valid[k] = 1'b0; err_clr[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) check_idle_zero(k, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1 lane: patterned load with gaps, ready held off for 5 cycles.
    for (int i = 0; i < W; i++) w[i] = i[0] ^ i[3];
    load_frame(0, w, 16'hA5C3, 1'b1, 5, 1'b0);

    // 4 lanes: replicated constant unload.
    rep = {7{32'h1234_5678}};
    unload_frame(1, rep[W-1:0], 16'h0F0F, 3, -1, 1'b0);

    // 5 lanes: all-ones in both directions, last unload beat carries pad 0s.
    load_frame(2, {W{1'b1}}, 16'h5555, 1'b1, 2, 1'b0);
    unload_frame(2, {W{1'b1}}, 16'hAAAA, 0, -1, 1'b0);
    check("err_clean_5lane", 2, W'(err[2]), '0);

    // Protocol errors: beat during HOLD_IN and during SHIFT_OUT.
    load_frame(0, rand_word(), SW'($urandom), 1'b0, 3, 1'b1);
    unload_frame(1, rand_word(), SW'($urandom), 1, 10, 1'b0);
    unload_frame(1, rand_word(), SW'($urandom), 2, -1, 1'b1);
    err_clr[0] = 1'b1;
    @(negedge clk);
    err_clr[0] = 1'b0;
    check("err_clr_alone", 0, W'(err[0]), '0);

    // Reset mid-SHIFT_IN after 100 beats, then a clean full frame.
    send_beats(0, {W{1'b1}}, 16'hFFFF, 100, 1'b1);
    rst_n = 1'b0;
    #1;
    check_idle_zero(0, "mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_frame(0, rand_word(), 16'h1357, 1'b1, 1, 1'b0);

    // Back-to-back loads with ready asserted as ld_valid rises.
    load_frame(1, rand_word(), 16'h2468, 1'b0, 0, 1'b0);
    load_frame(1, rand_word(), 16'h9BDF, 1'b0, 0, 1'b0);
    check("b2b_no_err", 1, W'(err[1]), '0);

    // Random frames on random lanes.
    for (int n = 0; n < 8; n++) begin
      int k;
      k = $urandom_range(0, NI - 1);
      if ($urandom_range(0, 1) == 1)
        load_frame(k, rand_word(), SW'($urandom), 1'b1, $urandom_range(0, 4), 1'b0);
      else
        unload_frame(k, rand_word(), SW'($urandom), $urandom_range(0, 4), -1, 1'b0);
      check("rand_no_err", k, W'(err[k]), '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
